program_loader: RTL

- Writer side of the instruction-memory interface: the PA_RISC fetch stage reads instruction memory, and this block fills it.
- Receives a byte stream (valid/ready) and assembles big-endian 32-bit instruction words. Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU in reset via cpu_hold until the program image is loaded.
- Sits between the board-level byte source (UART/bench) and the instruction-memory write port.

---
 rtl/program_loader_if.sv | 41 ++++
 rtl/program_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Bundles the loader's byte stream, instruction-memory write port and
// status lines into one interface.
//   master : byte source / system side (drives start, num_words, byte_in,
//            byte_valid; observes everything else)
//   slave  : program_loader itself
// Signals:
//   start, num_words        load request and word count
//   byte_in, byte_valid,    byte stream, valid/ready handshake
//   byte_ready
//   im_we, im_addr, im_data instruction-memory write port (byte address)
//   busy, done, cpu_hold    load status; cpu_hold keeps the CPU in reset
//   err                     checksum mismatch (LOADER_CHECKSUM_EN builds)
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-2:0] num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_data;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic              err;

    modport master (
        output start, num_words, byte_in, byte_valid,
        input  byte_ready, im_we, im_addr, im_data, busy, done, cpu_hold, err
    );

    modport slave (
        input  start, num_words, byte_in, byte_valid,
        output byte_ready, im_we, im_addr, im_data, busy, done, cpu_hold, err
    );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Fills instruction memory from a byte stream. Bytes are assembled
// big-endian into 32-bit words, each word is written with a one-cycle im_we
// pulse at consecutive word addresses starting at BASE_ADDR (wrapping modulo
// 2^ADDR_W). cpu_hold stays high until the whole image is loaded.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    program_loader_if.slave (stream, memory write port, status)
// Parameters:
//   ADDR_W     byte-address width of instruction memory
//   BASE_ADDR  byte address of the first word (multiple of 4)
// Optional build macro:
//   LOADER_CHECKSUM_EN  after the last word, one extra byte is taken as a
//                       checksum; err flags (sum of all bytes) mod 256 != 0.
//                       Undefined: err is tied low.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int          ADDR_W    = 9,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t            r_state,      nx_state;
    logic [1:0]        r_byte_idx,   nx_byte_idx;
    logic [ADDR_W-2:0] r_remaining,  nx_remaining;
    logic              r_byte_ready, nx_byte_ready;
    logic              r_im_we,      nx_im_we;
    logic [ADDR_W-1:0] r_im_addr,    nx_im_addr;
    logic [31:0]       r_im_data,    nx_im_data;
    logic              r_busy,       nx_busy;
    logic              r_done,       nx_done;
    logic              r_cpu_hold,   nx_cpu_hold;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum,        nx_sum;
    logic              r_err,        nx_err;
`endif

    logic w_accept;

    // byte_ready is registered, so acceptance depends only on present state
    assign w_accept = bus.byte_valid && r_byte_ready;

    always_comb begin
        nx_state      = r_state;
        nx_byte_idx   = r_byte_idx;
        nx_remaining  = r_remaining;
        nx_byte_ready = r_byte_ready;
        nx_im_we      = 1'b0;
        nx_im_addr    = r_im_addr;
        nx_im_data    = r_im_data;
        nx_busy       = r_busy;
        nx_done       = r_done;
        nx_cpu_hold   = r_cpu_hold;
`ifdef LOADER_CHECKSUM_EN
        nx_sum        = r_sum;
        nx_err        = r_err;
`endif

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    nx_im_addr  = BASE;
                    nx_byte_idx = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    nx_sum      = '0;
                    nx_err      = 1'b0;
`endif
                    if (bus.num_words != '0) begin
                        nx_state      = S_LOAD;
                        nx_remaining  = bus.num_words;
                        nx_byte_ready = 1'b1;
                        nx_busy       = 1'b1;
                        nx_done       = 1'b0;
                        nx_cpu_hold   = 1'b1;
                    end else begin
                        // Empty image: release the CPU without writing
                        nx_state      = S_DONE;
                        nx_byte_ready = 1'b0;
                        nx_busy       = 1'b0;
                        nx_done       = 1'b1;
                        nx_cpu_hold   = 1'b0;
                    end
                end
            end

            S_LOAD: begin
                if (w_accept) begin
                    case (r_byte_idx)
                        2'd0:    nx_im_data[31:24] = bus.byte_in;
                        2'd1:    nx_im_data[23:16] = bus.byte_in;
                        2'd2:    nx_im_data[15:8]  = bus.byte_in;
                        default: nx_im_data[7:0]   = bus.byte_in;
                    endcase
                    nx_byte_idx = r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    nx_sum      = r_sum + bus.byte_in;
`endif
                    if (r_byte_idx == 2'd3) begin
                        nx_state      = S_WRITE;
                        nx_byte_ready = 1'b0;
                        nx_im_we      = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                nx_im_addr   = r_im_addr + ADDR_W'(4);
                nx_remaining = r_remaining - 1'b1;
                if (r_remaining == (ADDR_W-1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    nx_state      = S_CHECK;
                    nx_byte_ready = 1'b1;
`else
                    nx_state      = S_DONE;
                    nx_byte_ready = 1'b0;
                    nx_busy       = 1'b0;
                    nx_done       = 1'b1;
                    nx_cpu_hold   = 1'b0;
`endif
                end else begin
                    nx_state      = S_LOAD;
                    nx_byte_ready = 1'b1;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    nx_err        = ((r_sum + bus.byte_in) != 8'd0);
                    nx_state      = S_DONE;
                    nx_byte_ready = 1'b0;
                    nx_busy       = 1'b0;
                    nx_done       = 1'b1;
                    nx_cpu_hold   = 1'b0;
                end
            end
`endif

            default: begin
                nx_state      = S_IDLE;
                nx_byte_ready = 1'b0;
                nx_busy       = 1'b0;
                nx_done       = 1'b0;
                nx_cpu_hold   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= 2'd0;
            r_remaining  <= '0;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b0;
            r_im_addr    <= BASE;
            r_im_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_state      <= nx_state;
            r_byte_idx   <= nx_byte_idx;
            r_remaining  <= nx_remaining;
            r_byte_ready <= nx_byte_ready;
            r_im_we      <= nx_im_we;
            r_im_addr    <= nx_im_addr;
            r_im_data    <= nx_im_data;
            r_busy       <= nx_busy;
            r_done       <= nx_done;
            r_cpu_hold   <= nx_cpu_hold;
`ifdef LOADER_CHECKSUM_EN
            r_sum        <= nx_sum;
            r_err        <= nx_err;
`endif
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.im_we      = r_im_we;
    assign bus.im_addr    = r_im_addr;
    assign bus.im_data    = r_im_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.cpu_hold   = r_cpu_hold;
`ifdef LOADER_CHECKSUM_EN
    assign bus.err        = r_err;
`else
    assign bus.err        = 1'b0;
`endif

endmodule
